// File: rtl/dp_seq_pkg.sv
// Shared types for the datapath job sequencer: FSM state encoding, requester ID, default width.
package dp_seq_pkg;

    localparam int unsigned DefaultDw = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWait    = 2'd2,
        StCapture = 2'd3
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter; i_rr_ptr names the requester preferred on a tie.
module rr_arb2
    import dp_seq_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_rr_ptr,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    always_comb begin
        o_grant = 2'b00;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_rr_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/dp_job_sequencer.sv
// Shares a start/done datapath between two requesters, one job at a time, round-robin.
// Define DP_SEQ_TIMEOUT_EN to add a WAIT-state watchdog that completes a hung job with result_err.
module dp_job_sequencer
    import dp_seq_pkg::*;
#(
    parameter int unsigned DW             = DefaultDw,
    parameter int unsigned START_HOLD     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_req,
    input  logic [DW-1:0] i_data0,
    input  logic [DW-1:0] i_data1,
    output logic [1:0]    o_ack,
    output logic          o_dp_start,
    output logic [DW-1:0] o_dp_data,
    input  logic          i_dp_done,
    input  logic [DW-1:0] i_dp_out,
    output logic [DW-1:0] o_result,
    output logic          o_result_id,
    output logic          o_result_valid,
    output logic          o_result_err,
    output logic          o_busy
);

    localparam int unsigned CntMax = (START_HOLD > TIMEOUT_CYCLES) ? START_HOLD : TIMEOUT_CYCLES;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    state_e          r_state, w_state_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    logic [DW-1:0]   r_dp_data;
    logic [DW-1:0]   r_result;
    req_id_t         r_job_id;
    req_id_t         r_rr_ptr;
    req_id_t         r_result_id;
    logic            r_result_err;
    logic            r_done_prev;
    logic [1:0]      r_ack;
    logic [1:0]      w_grant;
    logic            w_arb_valid;
    logic            w_done_edge;
    logic            w_timeout;
    logic            w_grant_en;
    logic            w_capture_en;

    rr_arb2 u_arb (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_valid  (w_arb_valid)
    );

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_done_edge = ~r_done_prev & i_dp_done;
`ifdef DP_SEQ_TIMEOUT_EN
        w_timeout   = (r_state == StWait) && !w_done_edge && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
        w_timeout   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_arb_valid) begin
                    w_state_d = StIssue;
                    w_cnt_d   = '0;
                end
            end
            StIssue: begin
                if (r_cnt == CW'(START_HOLD - 1)) begin
                    w_state_d = StWait;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StWait: begin
                if (w_done_edge || w_timeout) begin
                    w_state_d = StCapture;
                end
`ifdef DP_SEQ_TIMEOUT_EN
                w_cnt_d = r_cnt + CW'(1);
`endif
            end
            StCapture: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    assign w_grant_en   = (r_state == StIdle) && w_arb_valid;
    assign w_capture_en = (r_state == StWait) && (w_state_d == StCapture);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_dp_data    <= '0;
            r_result     <= '0;
            r_job_id     <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_result_id  <= 1'b0;
            r_result_err <= 1'b0;
            r_done_prev  <= 1'b0;
            r_ack        <= 2'b00;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ack   <= 2'b00;
            if (w_grant_en) begin
                r_dp_data   <= w_grant[1] ? i_data1 : i_data0;
                r_job_id    <= w_grant[1];
                r_ack       <= w_grant;
                r_done_prev <= i_dp_done;
            end
            // done_prev is frozen through ISSUE so a stale Done must fall inside WAIT first
            if (r_state == StWait) begin
                r_done_prev <= i_dp_done;
            end
            if (w_capture_en) begin
                r_result     <= w_timeout ? '0 : i_dp_out;
                r_result_id  <= r_job_id;
                r_result_err <= w_timeout;
            end
            if (r_state == StCapture) begin
                r_rr_ptr <= ~r_job_id;
            end
        end
    end

    assign o_ack          = r_ack;
    assign o_dp_start     = (r_state == StIssue);
    assign o_dp_data      = r_dp_data;
    assign o_result       = r_result;
    assign o_result_id    = r_result_id;
    assign o_result_valid = (r_state == StCapture);
    assign o_result_err   = r_result_err;
    assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_dp_job_sequencer.sv
// Self-checking bench for dp_job_sequencer with a behavioural datapath and arbitration model.
module tb_dp_job_sequencer;

    localparam int DW   = 16;
    localparam int HOLD = 4;
`ifdef DP_SEQ_TIMEOUT_EN
    localparam int TMO  = 16;
`else
    localparam int TMO  = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [DW-1:0] data0, data1;
    logic [1:0]    ack;
    logic          dp_start;
    logic [DW-1:0] dp_data;
    logic          dp_done;
    logic [DW-1:0] dp_out;
    logic [DW-1:0] result;
    logic          result_id, result_valid, result_err, busy;

    int            n_checks = 0;
    int            n_errors = 0;
    bit            m_ptr    = 1'b0;
    int            dp_delay = 10;
    logic [DW-1:0] dp_val   = '0;
    bit            dp_sticky = 1'b0;
    bit            dp_never  = 1'b0;
    bit            dp_raised = 1'b0;

    dp_job_sequencer #(
        .DW             (DW),
        .START_HOLD     (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_data0        (data0),
        .i_data1        (data1),
        .o_ack          (ack),
        .o_dp_start     (dp_start),
        .o_dp_data      (dp_data),
        .i_dp_done      (dp_done),
        .i_dp_out       (dp_out),
        .o_result       (result),
        .o_result_id    (result_id),
        .o_result_valid (result_valid),
        .o_result_err   (result_err),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: Done falls on Start (unless sticky) and rises dp_delay cycles after Start ends.
    initial begin
        dp_done = 1'b0;
        dp_out  = '0;
        forever begin
            do @(negedge clk); while (dp_start !== 1'b1);
            dp_raised = 1'b0;
            if (!dp_sticky) dp_done = 1'b0;
            do @(negedge clk); while (dp_start !== 1'b0);
            if (dp_sticky) begin
                repeat (2) @(negedge clk);
                dp_done = 1'b0;
            end
            if (!dp_never) begin
                repeat (dp_delay) @(negedge clk);
                dp_done   = 1'b1;
                dp_out    = dp_val;
                dp_raised = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
        @(negedge clk);
    endtask

    // One job: model picks the winner from the level requests and the reference pointer.
    task automatic do_job(input logic [1:0] add_now, input logic [1:0] add_busy, input bit keep,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] val, input int delay, input bit sticky,
                          input bit exp_err);
        bit            w;
        bit            got;
        int            n;
        logic [1:0]    exp_ack;
        logic [DW-1:0] exp_data, exp_res;
        data0     = d0;
        data1     = d1;
        dp_val    = val;
        dp_delay  = delay;
        dp_sticky = sticky;
        req       = req | add_now;
        w         = (req == 2'b11) ? m_ptr : req[1];
        exp_ack   = w ? 2'b10 : 2'b01;
        exp_data  = w ? d1 : d0;
        exp_res   = exp_err ? '0 : val;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (ack !== 2'b00);
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL ack_wait: no ack within 20 cycles, required %b", exp_ack);
            return;
        end
        n_checks++;
        if (ack !== exp_ack) begin
            n_errors++;
            $display("FAIL ack_value: got %b, required %b", ack, exp_ack);
        end
        n_checks++;
        if (dp_data !== exp_data) begin
            n_errors++;
            $display("FAIL dp_data_latch: got %h, required %h", dp_data, exp_data);
        end
        if (!keep) req[w] = 1'b0;
        req   = req | add_busy;
        data0 = DW'($urandom);
        data1 = DW'($urandom);
        n = 1;
        @(negedge clk);
        n_checks++;
        if (ack !== 2'b00) begin
            n_errors++;
            $display("FAIL ack_pulse: got %b one cycle later, required 00", ack);
        end
        while (dp_start === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != HOLD) begin
            n_errors++;
            $display("FAIL start_hold: dp_start high %0d cycles, required %0d", n, HOLD);
        end
        n = 0;
        while (result_valid !== 1'b1 && n < TMO + 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (result_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL result_wait: no result_valid after %0d cycles, required 1", n);
            return;
        end
        n_checks++;
        if (result !== exp_res || result_id !== w || result_err !== exp_err) begin
            n_errors++;
            $display("FAIL result: got %h id %b err %b, required %h id %b err %b",
                     result, result_id, result_err, exp_res, w, exp_err);
        end
        n_checks++;
        if (dp_data !== exp_data) begin
            n_errors++;
            $display("FAIL dp_data_stable: got %h at capture, required %h", dp_data, exp_data);
        end
        if (sticky) begin
            n_checks++;
            if (dp_raised !== 1'b1) begin
                n_errors++;
                $display("FAIL stale_done: captured with new edge %b, required 1", dp_raised);
            end
        end
        if (exp_err) begin
            n_checks++;
            if (n != TMO) begin
                n_errors++;
                $display("FAIL timeout_latency: %0d cycles after WAIT entry, required %0d", n, TMO);
            end
        end
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || result !== exp_res || result_id !== w) begin
            n_errors++;
            $display("FAIL result_hold: valid %b result %h id %b, required 0 %h %b",
                     result_valid, result, result_id, exp_res, w);
        end
        m_ptr = !w;
    endtask

    task automatic test_reset();
        data0 = '0;
        data1 = '0;
        apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ack, dp_start, dp_data, result, result_id, result_valid, result_err, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {ack, dp_start, dp_data, result, result_id, result_valid, result_err, busy});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ack !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy %b ack %b, required 0 00", busy, ack);
        end
    endtask

    task automatic test_basic();
        do_job(2'b01, 2'b00, 1'b0, 16'h0025, 16'h1234, 16'h0037, 10, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            do_job((k == 0) ? 2'b11 : 2'b00, 2'b00, 1'b1, 16'h0001, 16'h0002, DW'($urandom),
                   $urandom_range(1, 8), 1'b0, 1'b0);
        end
        req = 2'b00;
    endtask

    task automatic test_stale_done();
        do_job(2'b01, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 3, 1'b1, 1'b0);
        do_job(2'b10, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 2, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_job();
        bit got;
        do_job(2'b01, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 4, 1'b0, 1'b0);
        dp_delay  = 10;
        dp_sticky = 1'b0;
        req = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (ack !== 2'b00);
        end
        n_checks++;
        if (ack !== 2'b10) begin
            n_errors++;
            $display("FAIL mid_job_grant: got %b, required 10", ack);
        end
        req = 2'b00;
        for (int i = 0; i < 20 && (dp_start === 1'b1); i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack, dp_start, dp_data, result, result_id, result_valid, result_err, busy} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got %h, required 0",
                     {ack, dp_start, dp_data, result, result_id, result_valid, result_err, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_after_reset: got %b, required 0", busy);
        end
        do_job(2'b11, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 5, 1'b0, 1'b0);
        do_job(2'b00, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 5, 1'b0, 1'b0);
    endtask

    task automatic test_pending();
        bit seen;
        do_job(2'b01, 2'b11, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 6, 1'b0, 1'b0);
        do_job(2'b00, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 3, 1'b0, 1'b0);
        do_job(2'b00, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 7, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack !== 2'b00 || busy !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++;
            $display("FAIL pending_served_once: extra job started %b, required 0", seen);
        end
    endtask

`ifdef DP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        dp_never = 1'b1;
        do_job(2'b10, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 1, 1'b0, 1'b1);
        dp_never = 1'b0;
        do_job(2'b01, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 4, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            do_job(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 1'b0, DW'($urandom),
                   DW'($urandom), DW'($urandom), $urandom_range(1, 10),
                   1'($urandom_range(0, 1)), 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            if (req != 2'b00) begin
                do_job(2'b00, 2'b00, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), 2,
                       1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        data0 = '0;
        data1 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stale_done();
        test_reset_mid_job();
        test_pending();
`ifdef DP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
